queue_level_encoder: RTL

Front-end stage of the reward path: tracks vehicle occupancy for four lanes from arrival and departure sensor lines, and quantizes each lane count into an L_WIDTH-bit congestion level. On a sample request it registers a snapshot L0..L3 with a one-cycle valid strobe, which feeds the reward decision stage and the state encoder directly. It also provides saturation and underflow sticky flags for software visibility.

---
 rtl/queue_level_encoder.sv | 120 ++++++++++++
 1 files changed

// File: rtl/queue_level_encoder.sv
// Per-lane vehicle occupancy counters driven by edge-detected arrival/departure
// sensors, quantized into congestion levels and snapshotted on request.
module queue_level_encoder #(
    parameter int L_WIDTH   = 4,
    parameter int C_WIDTH   = 8,
    parameter int LVL_SHIFT = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         arr,
    input  logic [3:0]         dep,
    input  logic               sample_req,
    input  logic               clr_counts,
    output logic [L_WIDTH-1:0] L0,
    output logic [L_WIDTH-1:0] L1,
    output logic [L_WIDTH-1:0] L2,
    output logic [L_WIDTH-1:0] L3,
    output logic               l_valid,
    output logic [3:0]         sat_flag,
    output logic [3:0]         unf_flag
);

    localparam int NL      = 4;
    localparam int EW      = (C_WIDTH > L_WIDTH) ? C_WIDTH : L_WIDTH;
    localparam int LVL_MAX = (2 ** L_WIDTH) - 1;
    localparam logic [C_WIDTH-1:0] CNT_MAX = '1;

    logic [3:0]         arr_q, arr_d, dep_q, dep_d;
    logic [3:0]         a_ev, d_ev;
    logic [C_WIDTH-1:0] cnt_q [NL];
    logic [C_WIDTH-1:0] cnt_d [NL];
    logic [C_WIDTH-1:0] cnt_n [NL];
    logic [L_WIDTH-1:0] lvl_q [NL];
    logic [L_WIDTH-1:0] lvl_d [NL];
    logic [L_WIDTH-1:0] lvl_n [NL];
    logic               l_valid_q, l_valid_d;
    logic [3:0]         sat_q, sat_d, unf_q, unf_d;

    // Edge registers reset high so a line already asserted at release is not an event.
    assign arr_d = arr;
    assign dep_d = dep;
    assign a_ev  = arr & ~arr_q;
    assign d_ev  = dep & ~dep_q;

    // cnt_n carries this cycle's events; the clear is applied only on the way into cnt_q.
    always_comb begin
        sat_d = sat_q;
        unf_d = unf_q;
        for (int i = 0; i < NL; i++) begin
            cnt_n[i] = cnt_q[i];
            case ({a_ev[i], d_ev[i]})
                2'b10: begin
                    if (cnt_q[i] == CNT_MAX) begin
                        if (!clr_counts) sat_d[i] = 1'b1;
                    end else begin
                        cnt_n[i] = cnt_q[i] + C_WIDTH'(1);
                    end
                end
                2'b01: begin
                    if (cnt_q[i] == '0) begin
                        if (!clr_counts) unf_d[i] = 1'b1;
                    end else begin
                        cnt_n[i] = cnt_q[i] - C_WIDTH'(1);
                    end
                end
                default: ;
            endcase
            cnt_d[i] = clr_counts ? '0 : cnt_n[i];
        end
    end

    generate
        for (genvar gi = 0; gi < NL; gi++) begin : g_lvl
            logic [EW-1:0] shifted;
            assign shifted   = EW'(cnt_n[gi]) >> LVL_SHIFT;
            assign lvl_n[gi] = (shifted > EW'(LVL_MAX)) ? L_WIDTH'(LVL_MAX)
                                                        : shifted[L_WIDTH-1:0];
        end
    endgenerate

    always_comb begin
        l_valid_d = sample_req;
        for (int i = 0; i < NL; i++) begin
            lvl_d[i] = sample_req ? lvl_n[i] : lvl_q[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arr_q     <= 4'hF;
            dep_q     <= 4'hF;
            l_valid_q <= 1'b0;
            sat_q     <= '0;
            unf_q     <= '0;
            for (int i = 0; i < NL; i++) begin
                cnt_q[i] <= '0;
                lvl_q[i] <= '0;
            end
        end else begin
            arr_q     <= arr_d;
            dep_q     <= dep_d;
            l_valid_q <= l_valid_d;
            sat_q     <= sat_d;
            unf_q     <= unf_d;
            for (int i = 0; i < NL; i++) begin
                cnt_q[i] <= cnt_d[i];
                lvl_q[i] <= lvl_d[i];
            end
        end
    end

    assign L0       = lvl_q[0];
    assign L1       = lvl_q[1];
    assign L2       = lvl_q[2];
    assign L3       = lvl_q[3];
    assign l_valid  = l_valid_q;
    assign sat_flag = sat_q;
    assign unf_flag = unf_q;

endmodule
